// File: rtl/note_sequencer.sv
// Note source selector for the tone generator: live keys, or (note, duration)
// segments recorded into a small buffer and replayed on a replay edge.
module note_sequencer #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 12
) (
  input  logic        sys_CLK,
  input  logic        reset,
  input  logic [2:0]  button,
  input  logic        replay,
  input  logic [6:0]  key,
  input  logic        high,
  input  logic        low,
  output logic [4:0]  note,
  output logic        note_on,
  output logic [10:0] light,
  output logic        busy
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ENT_W   = 5 + DUR_W;

  typedef enum logic [2:0] {ST_IDLE, ST_LIVE, ST_REC, ST_ARM, ST_PLAY} state_t;

  state_t state, next_state, mode;

  logic [6:0]         key_s;
  logic               high_s, low_s, replay_s, replay_d;
  logic [2:0]         button_s;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [ADDR_W:0]    count, count_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [DUR_W-1:0]   dur, dur_n, dur_inc, play_cnt, play_cnt_n, cur_dur;
  logic [DUR_W:0]     play_cnt_inc;
  logic [4:0]         seg_note, seg_note_n, live_note, out_note;
  logic [2:0]         live_idx;
  logic [1:0]         live_oct;
  logic [10:0]        light_n;
  logic               tick, replay_edge, entry_done, last_entry, play_start;
  logic               wr_en;
  logic [ENT_W-1:0]   wr_data;

  // Stage S: every board input is registered exactly once
  always_ff @(posedge sys_CLK) begin
    if (reset) begin
      key_s    <= '0;
      high_s   <= 1'b0;
      low_s    <= 1'b0;
      button_s <= '0;
      replay_s <= 1'b0;
      replay_d <= 1'b0;
    end else begin
      key_s    <= key;
      high_s   <= high;
      low_s    <= low;
      button_s <= button;
      replay_s <= replay;
      replay_d <= replay_s;
    end
  end

  always_comb begin
    live_idx = '0;
    for (int i = 6; i >= 0; i--) begin
      if (key_s[i]) live_idx = 3'(i + 1);
    end
    if (high_s && !low_s)      live_oct = 2'b10;
    else if (low_s && !high_s) live_oct = 2'b00;
    else                       live_oct = 2'b01;
    live_note = {live_oct, live_idx};
  end

  always_comb begin
    case (button_s)
      3'b100:  mode = ST_LIVE;
      3'b010:  mode = ST_REC;
      3'b001:  mode = ST_ARM;
      default: mode = ST_IDLE;
    endcase
  end

  always_comb begin
    next_state   = state;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    count_n      = count;
    presc_n      = presc;
    dur_n        = dur;
    play_cnt_n   = play_cnt;
    seg_note_n   = seg_note;
    wr_en        = 1'b0;
    wr_data      = '0;
    out_note     = '0;
    light_n      = '0;

    replay_edge  = replay_s && !replay_d;
    tick         = (presc == PRESC_W'(TICK_DIV - 1));
    dur_inc      = (tick && (dur != {DUR_W{1'b1}})) ? dur + DUR_W'(1) : dur;
    cur_dur      = mem[rd_ptr][DUR_W-1:0];
    play_cnt_inc = {1'b0, play_cnt} + (DUR_W + 1)'(1);
    entry_done   = (state == ST_PLAY) && tick && (play_cnt_inc >= {1'b0, cur_dur});
    last_entry   = (({1'b0, rd_ptr} + (ADDR_W + 1)'(1)) == count);
    play_start   = (mode == ST_ARM) && ((state == ST_ARM) || (state == ST_PLAY)) &&
                   replay_edge && (count != '0);

    if (mode != ST_ARM)                              next_state = mode;
    else if (state != ST_ARM && state != ST_PLAY)    next_state = ST_ARM;
    else if (play_start)                             next_state = ST_PLAY;
    else if (entry_done && last_entry)               next_state = ST_ARM;

    // A segment closes when the live note changes or REC is left; the tick
    // landing on the closing edge still belongs to the closing segment.
    if (state == ST_REC) begin
      if ((next_state != ST_REC) || (live_note != seg_note)) begin
        if ((dur_inc != '0) && (count != (ADDR_W + 1)'(DEPTH))) begin
          wr_en    = 1'b1;
          wr_data  = {seg_note, dur_inc};
          wr_ptr_n = wr_ptr + ADDR_W'(1);
          count_n  = count + (ADDR_W + 1)'(1);
        end
        dur_n      = '0;
        presc_n    = '0;
        seg_note_n = live_note;
      end else begin
        dur_n   = dur_inc;
        presc_n = tick ? '0 : presc + PRESC_W'(1);
      end
    end else if (next_state == ST_REC) begin
      wr_ptr_n   = '0;
      count_n    = '0;
      dur_n      = '0;
      presc_n    = '0;
      seg_note_n = live_note;
    end

    if (play_start) begin
      rd_ptr_n   = '0;
      play_cnt_n = '0;
      presc_n    = '0;
    end else if ((state == ST_PLAY) && (next_state == ST_PLAY)) begin
      presc_n = tick ? '0 : presc + PRESC_W'(1);
      if (entry_done) begin
        rd_ptr_n   = rd_ptr + ADDR_W'(1);
        play_cnt_n = '0;
      end else if (tick) begin
        play_cnt_n = play_cnt_inc[DUR_W-1:0];
      end
    end

    if ((next_state != ST_REC) && (next_state != ST_PLAY)) presc_n = '0;

    case (next_state)
      ST_LIVE, ST_REC: out_note = live_note;
      ST_PLAY:         out_note = mem[rd_ptr_n][ENT_W-1 -: 5];
      default:         out_note = '0;
    endcase

    for (int i = 0; i < 7; i++) begin
      light_n[i] = (out_note[2:0] == 3'(i + 1));
    end
    light_n[7]  = (next_state == ST_REC);
    light_n[8]  = (next_state == ST_PLAY);
    light_n[9]  = (count_n == (ADDR_W + 1)'(DEPTH));
    light_n[10] = (next_state == ST_ARM) && (count_n != '0);
  end

  always_ff @(posedge sys_CLK) begin
    if (reset) begin
      state    <= ST_IDLE;
      note     <= '0;
      note_on  <= 1'b0;
      light    <= '0;
      busy     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      presc    <= '0;
      dur      <= '0;
      play_cnt <= '0;
      seg_note <= '0;
    end else begin
      state    <= next_state;
      note     <= out_note;
      note_on  <= (out_note[2:0] != 3'b000);
      light    <= light_n;
      busy     <= (next_state == ST_REC) || (next_state == ST_PLAY);
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      presc    <= presc_n;
      dur      <= dur_n;
      play_cnt <= play_cnt_n;
      seg_note <= seg_note_n;
    end
  end

  // Buffer contents survive reset; count gates whether they are ever read
  always_ff @(posedge sys_CLK) begin
    if (wr_en && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Controller and scheduler for the keyboard tone datapath. It owns the tone generator's note input and selects between two sources: live key presses, and a recorded note sequence played back from an internal buffer.
- It records key/octave activity as (note, duration) segments and replays them on request. It also drives the 11 panel lights.
- It sits between the board inputs (button, replay, key, high, low) and the tone generator, which turns `note`/`note_on` into `audio`.

Parameters:
- DEPTH, 32, number of recorded segments (power of two).
- ADDR_W, 5, log2(DEPTH).
- TICK_DIV, 50000, sys_CLK cycles per duration tick (1 ms at 50 MHz).
- DUR_W, 12, width of the duration field in ticks.

Ports:
- sys_CLK  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- button  in  3  mode select: 100 live, 010 record, 001 playback-armed; any other value means idle.
- replay  in  1  level input; a rising edge starts playback.
- key  in  7  piano keys; bit i is note i+1 (do..ti).
- high  in  1  octave up.
- low  in  1  octave down.
- note  out  5  {oct[1:0], idx[2:0]}; oct 00 low, 01 mid, 10 high; idx 0 means silence.
- note_on  out  1  high when idx != 0 is being driven.
- light  out  11  [6:0] one-hot current idx, [7] recording, [8] playing, [9] buffer full, [10] armed with count>0.
- busy  out  1  high in REC or PLAY.

Behaviour:
- Reset:
  - Clears to 0: note, note_on, light, busy, wr_ptr, rd_ptr, count, prescaler, duration counter, replay edge register.
  - State goes to IDLE.
  - Buffer RAM is not cleared; count=0 makes it unreadable.
- Input sampling: key, high, low, button and replay are registered once (stage S).
- Live note (computed from stage S):
  - idx = lowest set key bit + 1, or 0 if no key is set.
  - oct = 10 if high&~low, 00 if low&~high, otherwise 01.
- Output register:
  - note/note_on are registered from the selected source.
  - A live input change sampled at edge k appears on `note` after edge k+1.
- States: IDLE, LIVE, REC, ARM, PLAY. Mode decode from stage-S button:
  - 100 → LIVE; 010 → REC; 001 → ARM; other → IDLE.
  - A mode change takes effect at the next edge from any state, including mid-PLAY or mid-REC.
- IDLE and ARM: note=0, note_on=0.
- LIVE: note follows the live note.
- Prescaler:
  - Counts 0..TICK_DIV-1 and pulses `tick` at wrap.
  - Resets to 0 on entering REC, on each segment boundary in REC, and on each PLAY start.
- REC:
  - Entry clears wr_ptr, count and dur. `note` follows the live note.
  - dur increments on tick and saturates at 2^DUR_W-1 (no split).
  - When the live note changes, the previous segment {note, dur} is written at wr_ptr, then wr_ptr++ and count++, and dur restarts at 0.
  - A segment with dur==0 (shorter than one tick) is discarded.
  - Leaving REC flushes the open segment under the same rules.
  - Full (count==DEPTH): further writes are dropped, light[9]=1, and recording continues audibly.
- ARM:
  - A replay rising edge with count>0 → PLAY. rd_ptr=0, entry 0 is loaded, and its note is driven on the edge after detection.
  - A replay edge with count==0 is ignored.
- PLAY:
  - Drives the loaded entry's note and counts ticks.
  - When the tick count reaches the entry's dur, the next entry is driven on the following cycle; there are no silence gaps between entries.
  - After entry count-1 completes → ARM, note=0.
  - A replay edge during PLAY restarts from entry 0.
  - Live keys are ignored during PLAY.
- Lights:
  - light[6:0] is one-hot of the driven idx (0 when idx is 0).
  - light[7] = REC, light[8] = PLAY, light[9] = (count==DEPTH), light[10] = ARM&&count>0.
  - All lights are registered with `note`.
- Reset asserted mid-REC or mid-PLAY: outputs are silent the next cycle and the recording is lost.

Test Plan:
- TICK_DIV=4, DEPTH=4. Assert reset 2 cycles; set button=100, key=0000001 → note=5'b01001, note_on=1, light=11'b00000000001 two edges after key; then add high=1 → note=5'b10001.
- key=0000110 in LIVE, then high=1 and low=1 together → idx=2, oct=01, note=5'b01010.
- button=010; key=0000001 for 12 cycles, then key=0000100 for 8 cycles, then button=001 → count=2, entries {01001, dur 3}, {01011, dur 2}; light[10]=1.
- Continuing: replay pulse → note=01001 for 12 cycles, then 01011 for 8 cycles, then 0 with state ARM; light[8] high throughout playback.
- Record 6 distinct notes of 8 cycles each → count=4, light[9]=1; entries 5–6 are not stored, and playback yields only the first 4.
- During PLAY: a replay pulse restarts at entry 0; button=100 makes the next note the live note with light[8]=0; reset makes note=0 and count=0 next cycle, and a later replay in ARM does nothing.
